// File: rtl/gcd_arbiter_if.sv
// gcd_arbiter_if: requester-side bus of the gcd arbiter.
// Bundles the N request channels (valid/operands/ready) and the shared
// response channel (one-hot valid, result, error qualifier).
interface gcd_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_result;
    logic           rsp_err;

    // Requester side: raises requests, consumes accept and response pulses.
    modport master (
        output req_valid,
        output req_a,
        output req_b,
        input  req_ready,
        input  rsp_valid,
        input  rsp_result,
        input  rsp_err
    );

    // Arbiter side.
    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        output req_ready,
        output rsp_valid,
        output rsp_result,
        output rsp_err
    );
endinterface

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one iterative gcd engine among N requesters with
// round-robin arbitration. Zero-operand pairs are answered locally (a|b).
// Build macro GCD_TIMEOUT_EN adds a WAIT-state watchdog that aborts a hung
// engine op with rsp_err=1 and a one-cycle gcd_rst pulse.
module gcd_arbiter #(
    parameter int N              = 4,
    parameter int W              = 32,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    gcd_arbiter_if.slave bus,
    output logic         busy,
    output logic         gcd_rst,
    output logic         gcd_start,
    output logic [W-1:0] gcd_a,
    output logic [W-1:0] gcd_b,
    input  logic [W-1:0] gcd_result,
    input  logic         gcd_done
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] g_q, g_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic [W-1:0]  rsp_result_q, rsp_result_d;
    logic          gcd_start_q, gcd_start_d;
    logic          busy_q, busy_d;

    logic [N-1:0]  req_ready_s;
    logic          grant_found_s;
    logic [PW-1:0] grant_s;
    logic [PW-1:0] idx_s;
    logic [W-1:0]  grant_a_s;
    logic [W-1:0]  grant_b_s;

`ifdef GCD_TIMEOUT_EN
    localparam logic [W-1:0] TIMEOUT_LAST = W'(TIMEOUT_CYCLES - 1);
    logic [W-1:0]  cnt_q, cnt_d;
    logic          rsp_err_q, rsp_err_d;
    logic          gcd_rst_q, gcd_rst_d;
`endif

    // Round-robin search: first pending request after the last grant, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_s       = ptr_q;
        idx_s         = ptr_q;
        for (int k = 1; k <= N; k++) begin
            idx_s = PW'((int'(ptr_q) + k) % N);
            if (!grant_found_s && bus.req_valid[idx_s]) begin
                grant_found_s = 1'b1;
                grant_s       = idx_s;
            end
        end
    end

    assign grant_a_s = bus.req_a[int'(grant_s) * W +: W];
    assign grant_b_s = bus.req_b[int'(grant_s) * W +: W];

    // Next state, grant latching and response formation.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        g_d          = g_q;
        a_d          = a_q;
        b_d          = b_q;
        req_ready_s  = {N{1'b0}};
        rsp_result_d = {W{1'b0}};
`ifdef GCD_TIMEOUT_EN
        cnt_d        = cnt_q;
        rsp_err_d    = 1'b0;
        gcd_rst_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    req_ready_s[grant_s] = 1'b1;
                    ptr_d                = grant_s;
                    g_d                  = grant_s;
                    a_d                  = grant_a_s;
                    b_d                  = grant_b_s;
                    if ((grant_a_s == {W{1'b0}}) || (grant_b_s == {W{1'b0}})) begin
                        // gcd(0,x)=x: answer without the engine.
                        state_d      = ST_RESP;
                        rsp_result_d = grant_a_s | grant_b_s;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // gcd_done may still show the previous op here; skip it.
                state_d = ST_WAIT;
`ifdef GCD_TIMEOUT_EN
                cnt_d   = {W{1'b0}};
`endif
            end
            ST_WAIT: begin
                if (gcd_done) begin
                    state_d      = ST_RESP;
                    rsp_result_d = gcd_result;
                end
`ifdef GCD_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                    gcd_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
                end
`else
                else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        gcd_start_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP) ? ({{(N-1){1'b0}}, 1'b1} << g_d) : {N{1'b0}};
    end

    // State, operand latch and registered outputs; rst abandons any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= PW'(N - 1);
            g_q          <= {PW{1'b0}};
            a_q          <= {W{1'b0}};
            b_q          <= {W{1'b0}};
            rsp_valid_q  <= {N{1'b0}};
            rsp_result_q <= {W{1'b0}};
            gcd_start_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            g_q          <= g_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            gcd_start_q  <= gcd_start_d;
            busy_q       <= busy_d;
        end
    end

`ifdef GCD_TIMEOUT_EN
    // Watchdog counter and timeout-response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= {W{1'b0}};
            rsp_err_q <= 1'b0;
            gcd_rst_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
            gcd_rst_q <= gcd_rst_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
    assign gcd_rst     = rst | gcd_rst_q;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
    assign bus.rsp_err      = 1'b0;
    assign gcd_rst          = rst;
`endif

    assign bus.req_ready  = req_ready_s;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign busy           = busy_q;
    assign gcd_start      = gcd_start_q;
    assign gcd_a          = a_q;
    assign gcd_b          = b_q;
endmodule
